controlador_interrupcao_multi: RTL and testbench

Parametrised successor of the single-source interrupt controller. It accepts N_IRQ external interrupt lines (watchdog, timer, I/O, ...) and latches their rising edges into pending bits. It applies a software-writable mask and raises intr to the Control Unit. On ack it records a prioritised cause code and a PC backup, then holds off further interrupts until the handler returns via clr.

---
 rtl/controlador_interrupcao_multi.sv | 104 ++++++++++
 tb/tb_controlador_interrupcao_multi.sv | 138 +++++++++++++
 2 files changed

// File: rtl/controlador_interrupcao_multi.sv
// Multi-source interrupt controller: latches rising edges of N_IRQ lines, masks them,
// and hands the lowest-index enabled source to the Control Unit with a PC backup.
module controlador_interrupcao_multi #(
   parameter int unsigned      N_IRQ    = 4,
   parameter int unsigned      PC_W     = 26,
   parameter logic [N_IRQ-1:0] MASK_RST = '1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_IRQ-1:0] irq,
   input  logic [PC_W-1:0]  pc,
   input  logic             ack,
   input  logic             clr,
   input  logic             mask_we,
   input  logic [N_IRQ-1:0] mask_in,
   output logic             intr,
   output logic [31:0]      cause,
   output logic [31:0]      pcBckp,
   output logic [N_IRQ-1:0] pending,
   output logic [N_IRQ-1:0] mask,
   output logic [N_IRQ-1:0] lost
);

   typedef enum logic {StIdle, StService} state_t;

   state_t           state_q, state_d;
   logic [N_IRQ-1:0] irq_prev_q;
   logic [N_IRQ-1:0] pending_q, pending_d;
   logic [N_IRQ-1:0] lost_q, lost_d;
   logic [N_IRQ-1:0] mask_q;
   logic [31:0]      cause_q;
   logic [31:0]      pc_bckp_q;

   logic [N_IRQ-1:0] edge_det;
   logic [N_IRQ-1:0] req;
   logic [N_IRQ-1:0] clr_vec;
   logic [3:0]       sel;
   logic             take;
   logic [PC_W-1:0]  pc_inc;

   assign edge_det = irq & ~irq_prev_q;
   assign req      = pending_q & mask_q;
   assign pc_inc   = pc + PC_W'(1);

   // clr has priority over ack, so an accept only happens without clr
   assign take = (state_q == StIdle) & ack & ~clr & (|req);

   always_comb begin
      sel = '0;
      for (int k = N_IRQ - 1; k >= 0; k--) begin
         if (req[k]) sel = 4'(k);
      end
   end

   // A new edge on the bit being serviced re-arms it and is not counted as lost
   always_comb begin
      clr_vec   = take ? (N_IRQ'(1) << sel) : '0;
      pending_d = (pending_q & ~clr_vec) | edge_det;
      lost_d    = lost_q | (edge_det & pending_q & ~clr_vec);
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= StIdle;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (clr)       state_d = StIdle;
      else if (take) state_d = StService;
   end

   always_comb begin
      intr = (state_q == StIdle) & (|req);
   end

   always_ff @(posedge clk) begin
      irq_prev_q <= irq;
      if (rst) begin
         pending_q <= '0;
         lost_q    <= '0;
         mask_q    <= MASK_RST;
         cause_q   <= '0;
         pc_bckp_q <= '0;
      end else begin
         pending_q <= pending_d;
         lost_q    <= lost_d;
         if (mask_we) mask_q <= mask_in;
         if (clr) begin
            cause_q <= '0;
         end else if (take) begin
            cause_q   <= 32'(sel) + 32'd1;
            pc_bckp_q <= 32'(pc_inc);
         end
      end
   end

   assign cause   = cause_q;
   assign pcBckp  = pc_bckp_q;
   assign pending = pending_q;
   assign mask    = mask_q;
   assign lost    = lost_q;

endmodule

// File: tb/tb_controlador_interrupcao_multi.sv
// Directed vector bench for controlador_interrupcao_multi (N_IRQ=4, PC_W=26).
module tb_controlador_interrupcao_multi;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  irq = '0;
   logic [25:0] pc = '0;
   logic        ack = 1'b0;
   logic        clr = 1'b0;
   logic        mask_we = 1'b0;
   logic [3:0]  mask_in = '0;
   logic        intr;
   logic [31:0] cause;
   logic [31:0] pcBckp;
   logic [3:0]  pending;
   logic [3:0]  mask;
   logic [3:0]  lost;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   controlador_interrupcao_multi #(
      .N_IRQ   (4),
      .PC_W    (26),
      .MASK_RST(4'b1111)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .irq    (irq),
      .pc     (pc),
      .ack    (ack),
      .clr    (clr),
      .mask_we(mask_we),
      .mask_in(mask_in),
      .intr   (intr),
      .cause  (cause),
      .pcBckp (pcBckp),
      .pending(pending),
      .mask   (mask),
      .lost   (lost)
   );

   typedef struct {
      string       name;
      logic        rst;
      logic [3:0]  irq;
      logic [25:0] pc;
      logic        ack;
      logic        clr;
      logic        we;
      logic [3:0]  min;
      logic        e_intr;
      logic [31:0] e_cause;
      logic [31:0] e_pcb;
      logic [3:0]  e_pend;
      logic [3:0]  e_mask;
      logic [3:0]  e_lost;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(string name, logic r, logic [3:0] i, logic [25:0] p,
                               logic a, logic c, logic w, logic [3:0] m, logic ei,
                               logic [31:0] ec, logic [31:0] ep, logic [3:0] epd,
                               logic [3:0] em, logic [3:0] el);
      vec_t v;
      v.name = name; v.rst = r; v.irq = i; v.pc = p; v.ack = a; v.clr = c; v.we = w;
      v.min = m; v.e_intr = ei; v.e_cause = ec; v.e_pcb = ep; v.e_pend = epd;
      v.e_mask = em; v.e_lost = el;
      return v;
   endfunction

   // Drive one cycle of inputs, then compare all outputs just after the edge
   task automatic run(input vec_t v);
      logic [76:0] got, exp;
      @(negedge clk);
      rst = v.rst; irq = v.irq; pc = v.pc; ack = v.ack; clr = v.clr;
      mask_we = v.we; mask_in = v.min;
      @(posedge clk);
      #1;
      got = {intr, cause, pcBckp, pending, mask, lost};
      exp = {v.e_intr, v.e_cause, v.e_pcb, v.e_pend, v.e_mask, v.e_lost};
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got intr=%b cause=%0d pcBckp=%h pend=%b mask=%b lost=%b, want intr=%b cause=%0d pcBckp=%h pend=%b mask=%b lost=%b",
                  v.name, intr, cause, pcBckp, pending, mask, lost, v.e_intr, v.e_cause,
                  v.e_pcb, v.e_pend, v.e_mask, v.e_lost);
      end
   endtask

   initial begin
      //                   name            rst irq     pc          ack clr we min   intr cause pcb      pend    mask    lost
      vecs.push_back(mk("reset",          1, 4'b0001, 26'h0,       0, 0, 0, 4'h0, 0, 0, 32'h0,   4'b0000, 4'b1111, 4'b0000));
      vecs.push_back(mk("held_high",      0, 4'b0001, 26'h0,       0, 0, 0, 4'h0, 0, 0, 32'h0,   4'b0000, 4'b1111, 4'b0000));
      vecs.push_back(mk("drop0",          0, 4'b0000, 26'h0,       0, 0, 0, 4'h0, 0, 0, 32'h0,   4'b0000, 4'b1111, 4'b0000));
      vecs.push_back(mk("rise0",          0, 4'b0001, 26'h0,       0, 0, 0, 4'h0, 1, 0, 32'h0,   4'b0001, 4'b1111, 4'b0000));
      vecs.push_back(mk("ack0",           0, 4'b0000, 26'h0,       1, 0, 0, 4'h0, 0, 1, 32'h1,   4'b0000, 4'b1111, 4'b0000));
      vecs.push_back(mk("clr0",           0, 4'b0000, 26'h0,       0, 1, 0, 4'h0, 0, 0, 32'h1,   4'b0000, 4'b1111, 4'b0000));
      vecs.push_back(mk("rise21",         0, 4'b0110, 26'h100,     0, 0, 0, 4'h0, 1, 0, 32'h1,   4'b0110, 4'b1111, 4'b0000));
      vecs.push_back(mk("ack_prio",       0, 4'b0110, 26'h100,     1, 0, 0, 4'h0, 0, 2, 32'h101, 4'b0100, 4'b1111, 4'b0000));
      vecs.push_back(mk("clr_reassert",   0, 4'b0110, 26'h0,       0, 1, 0, 4'h0, 1, 0, 32'h101, 4'b0100, 4'b1111, 4'b0000));
      vecs.push_back(mk("ack_pc_wrap",    0, 4'b0110, 26'h3FFFFFF, 1, 0, 0, 4'h0, 0, 3, 32'h0,   4'b0000, 4'b1111, 4'b0000));
      vecs.push_back(mk("clr2",           0, 4'b0000, 26'h0,       0, 1, 0, 4'h0, 0, 0, 32'h0,   4'b0000, 4'b1111, 4'b0000));
      vecs.push_back(mk("mask_1110",      0, 4'b0000, 26'h0,       0, 0, 1, 4'hE, 0, 0, 32'h0,   4'b0000, 4'b1110, 4'b0000));
      vecs.push_back(mk("masked_rise0",   0, 4'b0001, 26'h0,       0, 0, 0, 4'h0, 0, 0, 32'h0,   4'b0001, 4'b1110, 4'b0000));
      vecs.push_back(mk("ack_no_intr",    0, 4'b0001, 26'h5,       1, 0, 0, 4'h0, 0, 0, 32'h0,   4'b0001, 4'b1110, 4'b0000));
      vecs.push_back(mk("unmask",         0, 4'b0001, 26'h0,       0, 0, 1, 4'hF, 1, 0, 32'h0,   4'b0001, 4'b1111, 4'b0000));
      vecs.push_back(mk("ack_unmasked",   0, 4'b0001, 26'h10,      1, 0, 0, 4'h0, 0, 1, 32'h11,  4'b0000, 4'b1111, 4'b0000));
      vecs.push_back(mk("clr3",           0, 4'b0000, 26'h0,       0, 1, 0, 4'h0, 0, 0, 32'h11,  4'b0000, 4'b1111, 4'b0000));
      vecs.push_back(mk("rise3",          0, 4'b1000, 26'h0,       0, 0, 0, 4'h0, 1, 0, 32'h11,  4'b1000, 4'b1111, 4'b0000));
      vecs.push_back(mk("drop3",          0, 4'b0000, 26'h0,       0, 0, 0, 4'h0, 1, 0, 32'h11,  4'b1000, 4'b1111, 4'b0000));
      vecs.push_back(mk("rise3_lost",     0, 4'b1000, 26'h0,       0, 0, 0, 4'h0, 1, 0, 32'h11,  4'b1000, 4'b1111, 4'b1000));
      vecs.push_back(mk("ack3",           0, 4'b1000, 26'h20,      1, 0, 0, 4'h0, 0, 4, 32'h21,  4'b0000, 4'b1111, 4'b1000));
      vecs.push_back(mk("service_hold",   0, 4'b0000, 26'h0,       1, 0, 0, 4'h0, 0, 4, 32'h21,  4'b0000, 4'b1111, 4'b1000));

      foreach (vecs[i]) run(vecs[i]);

      // ack and clr together while in SERVICE: back to IDLE, pcBckp kept
      run(mk("svc_ack_clr",    0, 4'b0000, 26'h55, 1, 1, 0, 4'h0, 0, 0, 32'h21, 4'b0000, 4'b1111, 4'b1000));
      run(mk("rise1",          0, 4'b0010, 26'h0,  0, 0, 0, 4'h0, 1, 0, 32'h21, 4'b0010, 4'b1111, 4'b1000));
      // ack and clr together in IDLE with intr=1: ack ignored
      run(mk("idle_ack_clr",   0, 4'b0010, 26'h66, 1, 1, 0, 4'h0, 1, 0, 32'h21, 4'b0010, 4'b1111, 4'b1000));
      run(mk("drop1",          0, 4'b0000, 26'h0,  0, 0, 0, 4'h0, 1, 0, 32'h21, 4'b0010, 4'b1111, 4'b1000));
      // new edge on source 1 in the very cycle it is acked
      run(mk("ack_edge_same",  0, 4'b0010, 26'h40, 1, 0, 0, 4'h0, 0, 2, 32'h41, 4'b0010, 4'b1111, 4'b1000));
      run(mk("clr_rearmed",    0, 4'b0010, 26'h0,  0, 1, 0, 4'h0, 1, 0, 32'h41, 4'b0010, 4'b1111, 4'b1000));
      // mask write coincident with ack: selection uses the old mask
      run(mk("ack_mask_we",    0, 4'b0010, 26'h0,  1, 0, 1, 4'hD, 0, 2, 32'h1,  4'b0000, 4'b1101, 4'b1000));
      run(mk("reset_again",    1, 4'b0010, 26'h0,  0, 0, 0, 4'h0, 0, 0, 32'h0,  4'b0000, 4'b1111, 4'b0000));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
